// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-style controller: state
// encodings, opcode/funct constants, ALU operation codes and datapath
// mux select values.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_LWWB   = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9,
    S_IEX    = 4'd10,
    S_IWB    = 4'd11,
    S_JR     = 4'd12,
    S_RSV13  = 4'd13,
    S_RSV14  = 4'd14,
    S_RSV15  = 4'd15
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function codes (IR[5:0]) that change control flow or operand routing
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_SLTU  = 3'b110;
  localparam logic [2:0] ALU_LUI   = 3'b111;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Register-file destination select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Instruction classifier: turns opcode/funct into the class flags the
// controller FSM dispatches on, plus the ALU op and extension mode used by
// immediate-format ALU instructions. Purely combinational.
module mc_decode (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_mem,
  output logic       is_lw,
  output logic       is_jr,
  output logic       is_jalr,
  output logic       is_rtype,
  output logic       is_shift,
  output logic       is_branch,
  output logic       is_bne,
  output logic       is_jump,
  output logic       is_jal,
  output logic       is_imm,
  output logic [2:0] imm_alu_op,
  output logic       imm_zext
);
  import mc_pkg::*;

  // Classify the instruction; anything unrecognised leaves every flag low
  always_comb begin
    is_mem     = 1'b0;
    is_lw      = 1'b0;
    is_jr      = 1'b0;
    is_jalr    = 1'b0;
    is_rtype   = 1'b0;
    is_shift   = 1'b0;
    is_branch  = 1'b0;
    is_bne     = 1'b0;
    is_jump    = 1'b0;
    is_jal     = 1'b0;
    is_imm     = 1'b0;
    imm_alu_op = ALU_ADD;
    imm_zext   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          is_jr   = 1'b1;
          is_jalr = (funct == FN_JALR);
        end else begin
          is_rtype = 1'b1;
          // Shifts take their first operand from the shamt field
          is_shift = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
        end
      end
      OP_BEQ: is_branch = 1'b1;
      OP_BNE: begin
        is_branch = 1'b1;
        is_bne    = 1'b1;
      end
      OP_J:   is_jump = 1'b1;
      OP_JAL: begin
        is_jump = 1'b1;
        is_jal  = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        is_imm     = 1'b1;
        imm_alu_op = ALU_ADD;
      end
      OP_SLTI: begin
        is_imm     = 1'b1;
        imm_alu_op = ALU_SLT;
      end
      OP_SLTIU: begin
        is_imm     = 1'b1;
        imm_alu_op = ALU_SLTU;
      end
      OP_ANDI: begin
        is_imm     = 1'b1;
        imm_alu_op = ALU_AND;
        imm_zext   = 1'b1;
      end
      OP_ORI: begin
        is_imm     = 1'b1;
        imm_alu_op = ALU_OR;
        imm_zext   = 1'b1;
      end
      OP_LUI: begin
        is_imm     = 1'b1;
        imm_alu_op = ALU_LUI;
      end
      OP_LW: begin
        is_mem = 1'b1;
        is_lw  = 1'b1;
      end
      OP_SW:   is_mem = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style controller. A Moore FSM steps each instruction
// through fetch, decode and its class-specific states; control outputs are
// decoded combinationally from the state (and IR fields / ALU zero where a
// state needs them). A retired-instruction counter ticks each time an
// instruction finishes and the FSM returns to fetch.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             reset,
  input  logic             clk,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             ext_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);
  import mc_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       dec_mem, dec_lw, dec_jr, dec_jalr, dec_rtype, dec_shift;
  logic       dec_branch, dec_bne, dec_jump, dec_jal, dec_imm, dec_imm_zext;
  logic [2:0] dec_imm_alu_op;

  mc_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
    .is_mem     (dec_mem),
    .is_lw      (dec_lw),
    .is_jr      (dec_jr),
    .is_jalr    (dec_jalr),
    .is_rtype   (dec_rtype),
    .is_shift   (dec_shift),
    .is_branch  (dec_branch),
    .is_bne     (dec_bne),
    .is_jump    (dec_jump),
    .is_jal     (dec_jal),
    .is_imm     (dec_imm),
    .imm_alu_op (dec_imm_alu_op),
    .imm_zext   (dec_imm_zext)
  );

  // State register; reset parks the FSM in fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  // An instruction retires on the edge that returns the FSM to fetch
  always_comb begin
    retired_d = retired_q;
    if (state_d == S_IF && state_q != S_IF) retired_d = retired_q + CNT_W'(1);
  end

  // Next-state and control decode; IR fields are only consulted after fetch
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = MTR_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    ext_op     = 1'b0;
    pc_source  = PCSRC_ALU;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        pc_source = PCSRC_ALU;
        pc_en     = 1'b1;
        state_d   = S_ID;
      end
      S_ID: begin
        // Precompute the branch target while decoding
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_IMM_SH2;
        alu_op    = ALU_ADD;
        ext_op    = 1'b1;
        if (dec_mem)         state_d = S_MEMADR;
        else if (dec_jr)     state_d = S_JR;
        else if (dec_rtype)  state_d = S_REX;
        else if (dec_branch) state_d = S_BR;
        else if (dec_jump)   state_d = S_JMP;
        else if (dec_imm)    state_d = S_IEX;
        else                 state_d = S_IF;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        ext_op    = 1'b1;
        state_d   = dec_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = S_LWWB;
      end
      S_LWWB: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RT;
        mem_to_reg = MTR_MDR;
        state_d    = S_IF;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = S_IF;
      end
      S_REX: begin
        alu_src_a = dec_shift ? SRCA_SHAMT : SRCA_A;
        alu_src_b = SRCB_B;
        alu_op    = ALU_FUNCT;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RD;
        mem_to_reg = MTR_ALUOUT;
        state_d    = S_IF;
      end
      S_BR: begin
        // Target was left in ALUOut by decode; the compare runs now
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_en     = dec_bne ? ~zero : zero;
        state_d   = S_IF;
      end
      S_JMP: begin
        pc_en     = 1'b1;
        pc_source = PCSRC_JUMP;
        if (dec_jal) begin
          reg_write  = 1'b1;
          reg_dst    = REGDST_RA;
          mem_to_reg = MTR_PC;
        end
        state_d = S_IF;
      end
      S_IEX: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = dec_imm_alu_op;
        ext_op    = ~dec_imm_zext;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RT;
        mem_to_reg = MTR_ALUOUT;
        state_d    = S_IF;
      end
      S_JR: begin
        pc_en     = 1'b1;
        pc_source = PCSRC_REG;
        if (dec_jalr) begin
          reg_write  = 1'b1;
          reg_dst    = REGDST_RD;
          mem_to_reg = MTR_PC;
        end
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
    // Fetch outputs would otherwise be live while reset holds the FSM in IF
    if (reset) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state_o = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model expands each
// instruction into its expected per-cycle control word; a compare process
// checks two DUT instances (32-bit and 4-bit counters) every cycle, plus
// literal pins taken from hand-worked examples.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_en, ir_write, mem_read, mem_write, iord, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b;
    logic [2:0] alu_op;
    logic       ext_op;
    logic [1:0] pc_source;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic zero;

  logic pc_en, ir_write, mem_read, mem_write, iord, reg_write, ext_op;
  logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state_o;
  logic [31:0] retired;

  logic d4_pc_en, d4_ir_write, d4_mem_read, d4_mem_write, d4_iord, d4_reg_write, d4_ext_op;
  logic [1:0] d4_reg_dst, d4_mem_to_reg, d4_alu_src_a, d4_alu_src_b, d4_pc_source;
  logic [2:0] d4_alu_op;
  logic [3:0] d4_state_o;
  logic [3:0] d4_retired;

  multicycle_controller dut (
    .reset(reset), .clk(clk), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
    .pc_source(pc_source), .state_o(state_o), .retired(retired)
  );

  multicycle_controller #(.CNT_W(4)) dut4 (
    .reset(reset), .clk(clk), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(d4_pc_en), .ir_write(d4_ir_write), .mem_read(d4_mem_read),
    .mem_write(d4_mem_write), .iord(d4_iord), .reg_write(d4_reg_write),
    .reg_dst(d4_reg_dst), .mem_to_reg(d4_mem_to_reg), .alu_src_a(d4_alu_src_a),
    .alu_src_b(d4_alu_src_b), .alu_op(d4_alu_op), .ext_op(d4_ext_op),
    .pc_source(d4_pc_source), .state_o(d4_state_o), .retired(d4_retired)
  );

  always #5 clk = ~clk;

  ctl_t act_c, act4_c;
  assign act_c = {state_o, pc_en, ir_write, mem_read, mem_write, iord, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op, pc_source};
  assign act4_c = {d4_state_o, d4_pc_en, d4_ir_write, d4_mem_read, d4_mem_write, d4_iord,
                   d4_reg_write, d4_reg_dst, d4_mem_to_reg, d4_alu_src_a, d4_alu_src_b,
                   d4_alu_op, d4_ext_op, d4_pc_source};

  // {pc_en, mem_read, reg_write, reg_dst, mem_to_reg, alu_src_a, pc_source}
  logic [10:0] act_key;
  assign act_key = {pc_en, mem_read, reg_write, reg_dst, mem_to_reg, alu_src_a, pc_source};

  // Expectations driven by the stimulus process
  ctl_t        exp_c;
  logic [31:0] exp_ret;
  logic        chk_en = 1'b0;
  logic        lit_state_en = 1'b0, lit_key_en = 1'b0, lit_ret_en = 1'b0, lit_ret4_en = 1'b0;
  logic [3:0]  lit_state = 4'd0;
  logic [10:0] lit_key = 11'd0;
  logic [31:0] lit_ret = 32'd0;
  logic [3:0]  lit_ret4 = 4'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] model_ret;
  ctl_t steps[$];

  // Single compare process, sampling mid-cycle
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (chk_en) begin
      checks++;
      if (act_c !== exp_c) begin
        errors++;
        $display("FAIL ctrl cyc=%0d got=%h want=%h", cyc, act_c, exp_c);
      end
      checks++;
      if (act4_c !== exp_c) begin
        errors++;
        $display("FAIL ctrl4 cyc=%0d got=%h want=%h", cyc, act4_c, exp_c);
      end
      checks++;
      if (retired !== exp_ret) begin
        errors++;
        $display("FAIL retired cyc=%0d got=%0d want=%0d", cyc, retired, exp_ret);
      end
      checks++;
      if (d4_retired !== exp_ret[3:0]) begin
        errors++;
        $display("FAIL retired4 cyc=%0d got=%0d want=%0d", cyc, d4_retired, exp_ret[3:0]);
      end
      if (lit_state_en) begin
        checks++;
        if (state_o !== lit_state) begin
          errors++;
          $display("FAIL lit_state cyc=%0d got=%0d want=%0d", cyc, state_o, lit_state);
        end
      end
      if (lit_key_en) begin
        checks++;
        if (act_key !== lit_key) begin
          errors++;
          $display("FAIL lit_key cyc=%0d got=%b want=%b", cyc, act_key, lit_key);
        end
      end
      if (lit_ret_en) begin
        checks++;
        if (retired !== lit_ret) begin
          errors++;
          $display("FAIL lit_retired cyc=%0d got=%0d want=%0d", cyc, retired, lit_ret);
        end
      end
      if (lit_ret4_en) begin
        checks++;
        if (d4_retired !== lit_ret4) begin
          errors++;
          $display("FAIL lit_retired4 cyc=%0d got=%0d want=%0d", cyc, d4_retired, lit_ret4);
        end
      end
    end
  end

  function automatic ctl_t blank(input logic [3:0] s);
    ctl_t c;
    c = '0;
    c.state = s;
    return c;
  endfunction

  function automatic ctl_t reset_word();
    ctl_t c;
    c = blank(4'd0);
    c.alu_src_b = 2'd1;
    return c;
  endfunction

  // Expand one instruction into the control words of every cycle it occupies
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    ctl_t c;
    steps.delete();
    c = blank(4'd0); c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 2'd1; c.pc_en = 1'b1;
    steps.push_back(c);
    c = blank(4'd1); c.alu_src_b = 2'd3; c.ext_op = 1'b1;
    steps.push_back(c);
    case (op)
      6'h23, 6'h2B: begin
        c = blank(4'd2); c.alu_src_a = 2'd1; c.alu_src_b = 2'd2; c.ext_op = 1'b1;
        steps.push_back(c);
        if (op == 6'h23) begin
          c = blank(4'd3); c.mem_read = 1'b1; c.iord = 1'b1; steps.push_back(c);
          c = blank(4'd4); c.reg_write = 1'b1; c.mem_to_reg = 2'd1; steps.push_back(c);
        end else begin
          c = blank(4'd5); c.mem_write = 1'b1; c.iord = 1'b1; steps.push_back(c);
        end
      end
      6'h00: begin
        if (fn == 6'h08 || fn == 6'h09) begin
          c = blank(4'd12); c.pc_en = 1'b1; c.pc_source = 2'd3;
          if (fn == 6'h09) begin c.reg_write = 1'b1; c.reg_dst = 2'd1; c.mem_to_reg = 2'd2; end
          steps.push_back(c);
        end else begin
          c = blank(4'd6);
          c.alu_src_a = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd2 : 2'd1;
          c.alu_op = 3'd2;
          steps.push_back(c);
          c = blank(4'd7); c.reg_write = 1'b1; c.reg_dst = 2'd1; steps.push_back(c);
        end
      end
      6'h04, 6'h05: begin
        c = blank(4'd8); c.alu_src_a = 2'd1; c.alu_op = 3'd1; c.pc_source = 2'd1;
        c.pc_en = (op == 6'h04) ? z : ~z;
        steps.push_back(c);
      end
      6'h02, 6'h03: begin
        c = blank(4'd9); c.pc_en = 1'b1; c.pc_source = 2'd2;
        if (op == 6'h03) begin c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2; end
        steps.push_back(c);
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F: begin
        c = blank(4'd10); c.alu_src_a = 2'd1; c.alu_src_b = 2'd2;
        case (op)
          6'h0A:   c.alu_op = 3'd5;
          6'h0B:   c.alu_op = 3'd6;
          6'h0C:   c.alu_op = 3'd3;
          6'h0D:   c.alu_op = 3'd4;
          6'h0F:   c.alu_op = 3'd7;
          default: c.alu_op = 3'd0;
        endcase
        c.ext_op = (op == 6'h0C || op == 6'h0D) ? 1'b0 : 1'b1;
        steps.push_back(c);
        c = blank(4'd11); c.reg_write = 1'b1; steps.push_back(c);
      end
      default: ;
    endcase
  endtask

  // Called at posedge+1 with the DUT in fetch; runs one whole instruction
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic [31:0] path, input int plen,
                           input int key_step, input logic [10:0] key);
    opcode = op; funct = fn; zero = z;
    build(op, fn, z);
    for (int k = 0; k < steps.size(); k++) begin
      exp_c = steps[k];
      exp_ret = model_ret;
      lit_state_en = (k < plen);
      lit_state = path[4*k +: 4];
      lit_key_en = (k == key_step);
      lit_key = key;
      chk_en = 1'b1;
      @(posedge clk); #1;
      lit_ret_en = 1'b0;
      lit_ret4_en = 1'b0;
    end
    lit_state_en = 1'b0;
    lit_key_en = 1'b0;
    model_ret = model_ret + 32'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_ret = 32'd0;
    exp_c = reset_word();
    exp_ret = 32'd0;
    lit_state_en = 1'b1; lit_state = 4'd0;
    lit_key_en = 1'b1; lit_key = 11'd0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    lit_state_en = 1'b0;
    lit_key_en = 1'b0;
  endtask

  // Start a lw, then pull reset while it sits in the memory-read cycle
  task automatic abort_lw();
    logic [15:0] p = 16'h3210;
    opcode = 6'h23; funct = 6'h00; zero = 1'b0;
    build(6'h23, 6'h00, 1'b0);
    exp_ret = model_ret;
    for (int k = 0; k < 4; k++) begin
      exp_c = steps[k];
      lit_state_en = 1'b1;
      lit_state = p[4*k +: 4];
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk); #2;
    reset = 1'b1;
    exp_c = reset_word();
    lit_state = 4'd0;
    lit_key_en = 1'b1; lit_key = 11'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    lit_state_en = 1'b0;
    lit_key_en = 1'b0;
  endtask

  logic [5:0] ops[15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                          6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h00};
  logic [5:0] fns[8]  = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h2A, 6'h21};

  initial begin
    int r;
    int f;
    logic [5:0] op, fn;
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    model_ret = 32'd0;
    exp_c = reset_word(); exp_ret = 32'd0;
    @(posedge clk); #1;
    do_reset();

    abort_lw();
    lit_ret_en = 1'b1; lit_ret = 32'd0;
    run_instr(6'h23, 6'h00, 1'b0, 32'h0004_3210, 5, 3, 11'b0_1_0_00_00_00_00);
    lit_ret_en = 1'b1; lit_ret = 32'd1;
    run_instr(6'h04, 6'h00, 1'b1, 32'h0000_0810, 3, 2, 11'b1_0_0_00_00_01_01);
    run_instr(6'h04, 6'h00, 1'b0, 32'h0000_0810, 3, 2, 11'b0_0_0_00_00_01_01);
    run_instr(6'h05, 6'h00, 1'b0, 32'h0000_0810, 3, 2, 11'b1_0_0_00_00_01_01);
    run_instr(6'h00, 6'h02, 1'b0, 32'h0000_7610, 4, 2, 11'b0_0_0_00_00_10_00);
    run_instr(6'h00, 6'h09, 1'b0, 32'h0000_0C10, 3, 2, 11'b1_0_1_01_10_00_11);
    run_instr(6'h03, 6'h00, 1'b0, 32'h0000_0910, 3, 2, 11'b1_0_1_10_10_00_10);
    lit_ret_en = 1'b1; lit_ret = 32'd7;
    run_instr(6'h3F, 6'h00, 1'b0, 32'h0000_0010, 2, -1, 11'd0);
    lit_ret_en = 1'b1; lit_ret = 32'd8;
    run_instr(6'h2B, 6'h00, 1'b0, 32'h0000_5210, 4, -1, 11'd0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 16);
      if (r < 15) op = ops[r[3:0]];
      else        op = 6'($urandom_range(0, 63));
      f = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
      else                           fn = fns[f[2:0]];
      run_instr(op, fn, 1'($urandom_range(0, 1)), 32'd0, 0, -1, 11'd0);
    end

    do_reset();
    for (int i = 0; i < 15; i++) run_instr(6'h2B, 6'h00, 1'b0, 32'd0, 0, -1, 11'd0);
    lit_ret4_en = 1'b1; lit_ret4 = 4'd15;
    run_instr(6'h2B, 6'h00, 1'b0, 32'd0, 0, -1, 11'd0);
    lit_ret4_en = 1'b1; lit_ret4 = 4'd0;
    lit_ret_en = 1'b1; lit_ret = 32'd16;
    run_instr(6'h3F, 6'h00, 1'b0, 32'd0, 0, -1, 11'd0);

    chk_en = 1'b0;
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
